// File: rtl/weight_router_pkg.sv
// Shared types and helpers for the weight router.
package weight_router_pkg;

  localparam int unsigned ROUTE_SIZE_WIDTH = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStream,
    StDone
  } wr_state_e;

  // Element index presented on a given lane of the beat starting at base.
  function automatic logic [ROUTE_SIZE_WIDTH-1:0] lane_index(
    input logic [ROUTE_SIZE_WIDTH-1:0] base,
    input int unsigned                 lane
  );
    return base + ROUTE_SIZE_WIDTH'(lane);
  endfunction

endpackage

// File: rtl/sram.sv
// Single-port-write / single-port-read SRAM, 1-cycle registered read, read-before-write.
module sram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_read_en,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_write_en) mem[i_write_addr] <= i_write_data;
    if (i_read_en) rdata_q <= mem[i_read_addr];
  end

  assign o_read_data = rdata_q;

endmodule

// File: rtl/wr_line_buffer.sv
// Kernel line buffer: whole-line writes, LANES-wide element reads starting at an element index.
module wr_line_buffer
  import weight_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ELEMS_PER_LINE = 8,
  parameter int unsigned DEPTH_LINES    = 4,
  parameter int unsigned LANES          = 2,
  localparam int unsigned SRAM_DW       = DATA_WIDTH * ELEMS_PER_LINE,
  localparam int unsigned SLOT_W        = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [SLOT_W-1:0]             i_wr_slot,
  input  logic [SRAM_DW-1:0]            i_wr_line,
  input  logic [ROUTE_SIZE_WIDTH-1:0]   i_rd_idx,
  output logic [LANES*DATA_WIDTH-1:0]   o_rd_elems
);

  localparam int unsigned TOTAL   = DEPTH_LINES * ELEMS_PER_LINE;
  localparam int unsigned ELEM_IW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [DATA_WIDTH-1:0] elem_q [TOTAL];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int j = 0; j < ELEMS_PER_LINE; j++) begin
        elem_q[ELEM_IW'(i_wr_slot * ELEMS_PER_LINE + j)] <= i_wr_line[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lanes past the end of the buffer read as zero.
  always_comb begin
    o_rd_elems = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_index(i_rd_idx, l) < ROUTE_SIZE_WIDTH'(TOTAL)) begin
        o_rd_elems[l*DATA_WIDTH +: DATA_WIDTH] = elem_q[ELEM_IW'(lane_index(i_rd_idx, l))];
      end
    end
  end

endmodule

// File: rtl/weight_router_mc.sv
// Weight router: fetches a kernel into a line buffer and streams it LANES elements per beat.
// Define WEIGHT_ROUTER_STALL_CNT_EN to add the o_stall_cnt port and counter.
module weight_router_mc
  import weight_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ELEMS_PER_LINE = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DEPTH_LINES    = 4,
  parameter int unsigned LANES          = 2,
  parameter int unsigned REUSE_WIDTH    = 8,
  localparam int unsigned SRAM_DW       = DATA_WIDTH * ELEMS_PER_LINE
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_sram_write_en,
  input  logic [ADDR_WIDTH-1:0]       i_write_addr,
  input  logic [SRAM_DW-1:0]          i_data_in,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_start_addr,
  input  logic [ADDR_WIDTH-1:0]       i_num_lines,
  input  logic [ROUTE_SIZE_WIDTH-1:0] i_route_size,
  input  logic [REUSE_WIDTH-1:0]      i_reuse_count,
  input  logic                        i_data_ready,
  output logic [LANES*DATA_WIDTH-1:0] o_data,
  output logic [LANES-1:0]            o_lane_valid,
  output logic                        o_data_valid,
  output logic                        o_last,
  output logic                        o_route_ready,
  output logic                        o_route_done,
  output logic                        o_err
`ifdef WEIGHT_ROUTER_STALL_CNT_EN
  ,
  output logic [31:0]                 o_stall_cnt
`endif
);

  localparam int unsigned SLOT_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned IDX_NW = ROUTE_SIZE_WIDTH + 1;

  if (ELEMS_PER_LINE % LANES != 0) begin : g_lanes_check
    $error("ELEMS_PER_LINE must be a multiple of LANES");
  end

  wr_state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]       start_addr_q, num_lines_q;
  logic [ROUTE_SIZE_WIDTH-1:0] route_size_q;
  logic [REUSE_WIDTH-1:0]      reuse_q;
  logic [ADDR_WIDTH-1:0]       fetch_k_q, fetch_k_d;
  logic [ROUTE_SIZE_WIDTH-1:0] idx_q, idx_d;
  logic [REUSE_WIDTH-1:0]      pass_q, pass_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        rr_q, rr_d;
  logic                        rd_pend_q;
  logic [SLOT_W-1:0]           rd_slot_q;

  logic                        start_ok, cfg_empty, cfg_bad;
  logic                        beat_valid, pass_end, final_pass;
  logic [IDX_NW-1:0]           idx_next;
  logic [SRAM_DW-1:0]          sram_rdata;
  logic [LANES*DATA_WIDTH-1:0] buf_elems;

  assign start_ok  = i_start && (state_q == StIdle || state_q == StDone);
  assign cfg_empty = (i_num_lines == '0) || (i_route_size == '0);
  assign cfg_bad   = (32'(i_num_lines) > DEPTH_LINES) ||
                     (32'(i_route_size) > 32'(i_num_lines) * ELEMS_PER_LINE);

  assign beat_valid = (state_q == StStream);
  assign idx_next   = {1'b0, idx_q} + IDX_NW'(LANES);
  assign pass_end   = idx_next >= {1'b0, route_size_q};
  assign final_pass = (pass_q == reuse_q);

  sram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (SRAM_DW)
  ) u_sram (
    .i_clk        (i_clk),
    .i_write_en   (i_sram_write_en),
    .i_write_addr (i_write_addr),
    .i_write_data (i_data_in),
    .i_read_en    (state_q == StFetch),
    .i_read_addr  (start_addr_q + fetch_k_q),
    .o_read_data  (sram_rdata)
  );

  wr_line_buffer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ELEMS_PER_LINE (ELEMS_PER_LINE),
    .DEPTH_LINES    (DEPTH_LINES),
    .LANES          (LANES)
  ) u_line_buffer (
    .i_clk      (i_clk),
    .i_wr_en    (rd_pend_q),
    .i_wr_slot  (rd_slot_q),
    .i_wr_line  (sram_rdata),
    .i_rd_idx   (idx_q),
    .o_rd_elems (buf_elems)
  );

  always_comb begin
    state_d   = state_q;
    fetch_k_d = fetch_k_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    done_d    = done_q;
    err_d     = err_q;
    rr_d      = rr_q;
    case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          rr_d      = 1'b0;
          fetch_k_d = '0;
          idx_d     = '0;
          pass_d    = '0;
          if (cfg_empty) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (cfg_bad) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        fetch_k_d = fetch_k_q + ADDR_WIDTH'(1);
        if (fetch_k_q == num_lines_q - ADDR_WIDTH'(1)) state_d = StWait;
      end
      StWait: begin
        state_d = StStream;
        rr_d    = 1'b1;
      end
      StStream: begin
        if (i_data_ready) begin
          if (pass_end) begin
            idx_d = '0;
            if (final_pass) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              pass_d = pass_q + REUSE_WIDTH'(1);
            end
          end else begin
            idx_d = idx_next[ROUTE_SIZE_WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state_q      <= StIdle;
      start_addr_q <= '0;
      num_lines_q  <= '0;
      route_size_q <= '0;
      reuse_q      <= '0;
      fetch_k_q    <= '0;
      idx_q        <= '0;
      pass_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rr_q         <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_slot_q    <= '0;
    end else begin
      state_q   <= state_d;
      fetch_k_q <= fetch_k_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rr_q      <= rr_d;
      rd_pend_q <= (state_q == StFetch);
      rd_slot_q <= SLOT_W'(fetch_k_q);
      if (start_ok) begin
        start_addr_q <= i_start_addr;
        num_lines_q  <= i_num_lines;
        route_size_q <= i_route_size;
        reuse_q      <= i_reuse_count;
      end
    end
  end

  // Beat outputs derive from idx and the frozen buffer, so they hold while stalled.
  always_comb begin
    o_lane_valid = '0;
    o_data       = '0;
    for (int l = 0; l < LANES; l++) begin
      if (beat_valid && lane_index(idx_q, l) < route_size_q) begin
        o_lane_valid[l]                    = 1'b1;
        o_data[l*DATA_WIDTH +: DATA_WIDTH] = buf_elems[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_data_valid  = beat_valid;
  assign o_last        = beat_valid && final_pass && pass_end;
  assign o_route_ready = rr_q;
  assign o_route_done  = done_q;
  assign o_err         = err_q;

`ifdef WEIGHT_ROUTER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || start_ok) begin
      stall_q <= '0;
    end else if (beat_valid && !i_data_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_weight_router_mc.sv
// Scoreboard bench for weight_router_mc; expected beats come from a flat element model of the SRAM.
module tb_weight_router_mc;

  localparam int EPL   = 8;
  localparam int DEPTH = 4;
  localparam int LANES = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  lv;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, clr, wen, start;
  logic [7:0]  waddr, saddr, nlines, reuse;
  logic [63:0] wdata;
  logic [15:0] rsize;
  logic        ready = 1'b1;
  logic [15:0] data;
  logic [1:0]  lv;
  logic        valid, last, rready, rdone, err;
`ifdef WEIGHT_ROUTER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  weight_router_mc dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_clear         (clr),
    .i_sram_write_en (wen),
    .i_write_addr    (waddr),
    .i_data_in       (wdata),
    .i_start         (start),
    .i_start_addr    (saddr),
    .i_num_lines     (nlines),
    .i_route_size    (rsize),
    .i_reuse_count   (reuse),
    .i_data_ready    (ready),
    .o_data          (data),
    .o_lane_valid    (lv),
    .o_data_valid    (valid),
    .o_last          (last),
    .o_route_ready   (rready),
    .o_route_done    (rdone),
    .o_err           (err)
`ifdef WEIGHT_ROUTER_STALL_CNT_EN
    ,
    .o_stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  logic [7:0] mem_m [256][8];

  bit   rand_ready = 1'b0;
  logic ready_fixed = 1'b1;
  always @(posedge clk) begin
    #2;
    ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  int    cyc = 0, accepted = 0, first_valid_cyc = -1, last_cyc = 0, stall_tb = 0;
  bit    prev_stall = 1'b0, expect_done = 1'b0;
  beat_t prev_beat, mon_t;

  always @(negedge clk) begin
    cyc++;
    if (expect_done) begin
      check("done_after_last", 64'(rdone), 64'd1);
      check("valid_after_last", 64'(valid), 64'd0);
      expect_done = 1'b0;
    end
    if (valid && !rst && !clr) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("hold_data", 64'(data), 64'(prev_beat.data));
        check("hold_lane_valid", 64'(lv), 64'(prev_beat.lv));
        check("hold_last", 64'(last), 64'(prev_beat.last));
      end
      if (ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, want no beat", data);
        end else begin
          mon_t = exp_q.pop_front();
          check("beat_data", 64'(data), 64'(mon_t.data));
          check("beat_lane_valid", 64'(lv), 64'(mon_t.lv));
          check("beat_last", 64'(last), 64'(mon_t.last));
          if (mon_t.last) expect_done = 1'b1;
        end
        accepted++;
        last_cyc   = cyc;
        prev_stall = 1'b0;
      end else begin
        stall_tb++;
        prev_stall = 1'b1;
        prev_beat  = '{data: data, lv: lv, last: last};
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input int a, input logic [63:0] line);
    for (int j = 0; j < EPL; j++) mem_m[a][j] = line[j*8 +: 8];
    wen = 1'b1;
    waddr = 8'(a);
    wdata = line;
    tick();
    wen = 1'b0;
  endtask

  task automatic write_seq_line(input int a, input int base);
    logic [63:0] line;
    for (int j = 0; j < EPL; j++) line[j*8 +: 8] = 8'(base + j);
    write_line(a, line);
  endtask

  task automatic push_stream(input int sa, input int sz, input int ru);
    beat_t t;
    for (int p = 0; p <= ru; p++) begin
      for (int b = 0; b < sz; b += LANES) begin
        t = '0;
        for (int l = 0; l < LANES; l++) begin
          int e = b + l;
          if (e < sz) begin
            t.lv[l] = 1'b1;
            t.data[l*8 +: 8] = mem_m[(sa + e / EPL) % 256][e % EPL];
          end
        end
        t.last = (p == ru) && (b + LANES >= sz);
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic do_start(input int sa, input int nl, input int sz, input int ru, input bit model);
    if (model) begin
      stall_tb = 0;
      accepted = 0;
      first_valid_cyc = -1;
      if (nl != 0 && sz != 0 && nl <= DEPTH && sz <= nl * EPL) push_stream(sa, sz, ru);
    end
    saddr = 8'(sa);
    nlines = 8'(nl);
    rsize = 16'(sz);
    reuse = 8'(ru);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (rdone || err) break;
      tick();
    end
    if (i == 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done/err, want done within 2000 cycles", name);
    end
  endtask

  task automatic run_check(input string name, input int beats, input bit contiguous);
    wait_end(name);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_done"}, 64'(rdone), 64'd1);
    check({name, "_err"}, 64'(err), 64'd0);
    check({name, "_route_ready"}, 64'(rready), 64'd1);
    check({name, "_beats"}, 64'(accepted), 64'(beats));
    if (contiguous) check({name, "_span"}, 64'(last_cyc - first_valid_cyc + 1), 64'(beats));
`ifdef WEIGHT_ROUTER_STALL_CNT_EN
    check({name, "_stall_cnt"}, 64'(stall_cnt), 64'(stall_tb));
`endif
  endtask

  task automatic wait_accepted(input int n, input string name);
    int i;
    for (i = 0; i < 500; i++) begin
      if (accepted >= n) break;
      tick();
    end
    if (i == 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats, want %0d", name, accepted, n);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wen = 1'b0; start = 1'b0;
    waddr = '0; wdata = '0; saddr = '0; nlines = '0; rsize = '0; reuse = '0;
    repeat (3) tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_lane_valid", 64'(lv), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    check("rst_route_ready", 64'(rready), 64'd0);
    check("rst_done", 64'(rdone), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    // Basic kernel: elements 0..15 in lines 0x10/0x11.
    write_seq_line(8'h10, 0);
    write_seq_line(8'h11, 8);
    do_start(8'h10, 2, 16, 0, 1'b1);
    run_check("basic", 8, 1'b1);

    // Partial last beat, three passes with no bubbles.
    do_start(8'h10, 2, 9, 2, 1'b1);
    run_check("reuse", 15, 1'b1);

    // Random configs under random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int sa = $urandom_range(0, 255);
      int nl = $urandom_range(1, DEPTH);
      int sz = $urandom_range(1, nl * EPL);
      int ru = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++) write_line((sa + k) % 256, {$urandom, $urandom});
      do_start(sa, nl, sz, ru, 1'b1);
      run_check("random", (ru + 1) * ((sz + LANES - 1) / LANES), 1'b0);
    end
    rand_ready = 1'b0;
    tick();

    // Bad and empty configurations.
    do_start(8'h10, 5, 16, 0, 1'b1);
    check("too_many_lines_err", 64'(err), 64'd1);
    check("too_many_lines_done", 64'(rdone), 64'd0);
    repeat (6) tick();
    check("too_many_lines_route_ready", 64'(rready), 64'd0);
    do_start(8'h10, 2, 17, 0, 1'b1);
    check("size_too_big_err", 64'(err), 64'd1);
    do_start(8'h10, 0, 4, 0, 1'b1);
    check("empty_done", 64'(rdone), 64'd1);
    check("empty_err", 64'(err), 64'd0);
    do_start(8'h10, 2, 16, 0, 1'b1);
    run_check("after_err", 8, 1'b1);

    // Clear mid-stream, then a full restart.
    do_start(8'h10, 2, 16, 1, 1'b1);
    wait_accepted(3, "clear_wait");
    clr = 1'b1;
    ready_fixed = 1'b0;
    tick();
    clr = 1'b0;
    check("clear_valid", 64'(valid), 64'd0);
    check("clear_route_ready", 64'(rready), 64'd0);
    check("clear_done", 64'(rdone), 64'd0);
    exp_q.delete();
    ready_fixed = 1'b1;
    tick();
    do_start(8'h10, 2, 16, 1, 1'b1);
    run_check("restart", 16, 1'b1);

    // Address wrap; a start pulsed during streaming is ignored.
    write_seq_line(8'hFF, 100);
    write_seq_line(8'h00, 200);
    do_start(8'hFF, 2, 16, 0, 1'b1);
    wait_accepted(1, "wrap_wait");
    do_start(8'h10, 1, 4, 0, 1'b0);
    run_check("wrap", 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
